// File: rtl/pow3_stream_checker.sv
// pow3_stream_checker: AXI-Stream sink checking beat n against 3**n mod 2**DATA_WIDTH.
// Define POW3_CHECKER_BACKPRESSURE_EN to drop tready every 4th cycle while running.
module pow3_stream_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    s00_axis_aclk,
  input  logic                    s00_axis_areset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic [COUNT_WIDTH-1:0]  beat_count,
  output logic [COUNT_WIDTH-1:0]  error_count,
  output logic [COUNT_WIDTH-1:0]  packet_count,
  output logic [DATA_WIDTH-1:0]   first_err_data,
  output logic [COUNT_WIDTH-1:0]  first_err_index,
  output logic                    error_flag,
  output logic                    done
);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic tready_q, tready_d, done_q, err_flag_q, xfer, mismatch, last_beat;
  logic [DATA_WIDTH-1:0] exp_q, fdata_q, mask;
  logic [COUNT_WIDTH-1:0] beat_q, err_q, pkt_q, fidx_q, beat_inc;
  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_mask
    assign mask[b*8 +: 8] = {8{s00_axis_tstrb[b]}};
  end
  assign xfer      = s00_axis_tvalid & tready_q;
  assign mismatch  = |((s00_axis_tdata ^ exp_q) & mask);
  assign beat_inc  = beat_q + ONE;
  assign last_beat = &beat_inc;
  // Saturating the beat counter wins over enable falling in the same cycle.
  assign state_d = (state_q == RUN && xfer && last_beat) ? DONE :
                   (state_q == RUN && !enable)           ? IDLE :
                   (state_q == IDLE && enable)           ? RUN  : state_q;
`ifdef POW3_CHECKER_BACKPRESSURE_EN
  logic [1:0] bp_q;
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) bp_q <= 2'd0;
    else bp_q <= clear ? 2'd0 : bp_q + 2'd1;
  end
  // tready is registered, so look at the counter value it will sit beside.
  assign tready_d = (state_d == RUN) && (bp_q + 2'd1 != 2'd3);
`else
  assign tready_d = state_d == RUN;
`endif
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      exp_q      <= DATA_WIDTH'(1);
      beat_q     <= '0;
      err_q      <= '0;
      pkt_q      <= '0;
      fdata_q    <= '0;
      fidx_q     <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      exp_q      <= DATA_WIDTH'(1);
      beat_q     <= '0;
      err_q      <= '0;
      pkt_q      <= '0;
      fdata_q    <= '0;
      fidx_q     <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      if (xfer) begin
        beat_q <= beat_inc;
        exp_q  <= exp_q + (exp_q << 1);
        if (s00_axis_tlast && !(&pkt_q)) pkt_q <= pkt_q + ONE;
        if (mismatch) begin
          if (!(&err_q)) err_q <= err_q + ONE;
          err_flag_q <= 1'b1;
          if (!err_flag_q) begin
            fdata_q <= s00_axis_tdata;
            fidx_q  <= beat_q;
          end
        end
        if (last_beat) done_q <= 1'b1;
      end
    end
  end
  assign s00_axis_tready = tready_q;
  assign beat_count      = beat_q;
  assign error_count     = err_q;
  assign packet_count    = pkt_q;
  assign first_err_data  = fdata_q;
  assign first_err_index = fidx_q;
  assign error_flag      = err_flag_q;
  assign done            = done_q;
endmodule

// File: tb/tb_pow3_stream_checker.sv
// tb_pow3_stream_checker: vector table plus scoreboard for pow3_stream_checker.
module tb_pow3_stream_checker;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic enable = 1'b0, clear = 1'b0, tvalid = 1'b0, tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0] tstrb = '0;
  logic tready, err_flag, done;
  logic [15:0] beat, err, pkt, fidx;
  logic [31:0] fdata;

  logic enable4 = 1'b0, clear4 = 1'b0, tvalid4 = 1'b0;
  logic [31:0] tdata4 = '0;
  logic tready4, err_flag4, done4;
  logic [3:0] beat4, err4, pkt4, fidx4;
  logic [31:0] fdata4;

  pow3_stream_checker dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .enable(enable), .clear(clear),
    .s00_axis_tdata(tdata), .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid),
    .s00_axis_tlast(tlast), .s00_axis_tready(tready), .beat_count(beat),
    .error_count(err), .packet_count(pkt), .first_err_data(fdata),
    .first_err_index(fidx), .error_flag(err_flag), .done(done)
  );

  pow3_stream_checker #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut4 (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .enable(enable4), .clear(clear4),
    .s00_axis_tdata(tdata4), .s00_axis_tstrb(4'hF), .s00_axis_tvalid(tvalid4),
    .s00_axis_tlast(1'b0), .s00_axis_tready(tready4), .beat_count(beat4),
    .error_count(err4), .packet_count(pkt4), .first_err_data(fdata4),
    .first_err_index(fidx4), .error_flag(err_flag4), .done(done4)
  );

  typedef struct {
    logic [15:0] beat, err, pkt;
    logic        flag;
    logic [31:0] fdata;
    logic [15:0] fidx;
  } exp_t;

  typedef struct {
    logic        clr;
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    logic        bad;
  } vec_t;

  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0;
  logic hs = 1'b0, sb_on = 1'b1;
  logic [15:0] m_beat, m_err, m_pkt, m_fidx;
  logic m_flag;
  logic [31:0] m_fdata, m_e;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  always @(posedge clk) hs <= tvalid && tready && !clear && !rst;

  always @(negedge clk) begin
    if (hs && sb_on) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: beat accepted with nothing expected, beat_count=%0d", beat);
      end else begin
        me = q.pop_front();
        chk("sb_beat_count", beat, me.beat);
        chk("sb_error_count", err, me.err);
        chk("sb_packet_count", pkt, me.pkt);
        chk("sb_error_flag", err_flag, me.flag);
        chk("sb_first_err_data", fdata, me.fdata);
        chk("sb_first_err_index", fidx, me.fidx);
      end
    end
  end

  task automatic model_reset();
    m_beat = '0; m_err = '0; m_pkt = '0; m_fidx = '0;
    m_flag = 1'b0; m_fdata = '0; m_e = 32'd1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic bad);
    for (int t = 0; t < 8 && !tready; t++) @(negedge clk);
    if (bad) begin
      if (!m_flag) begin
        m_fdata = d;
        m_fidx  = m_beat;
      end
      m_err++;
      m_flag = 1'b1;
    end
    m_beat++;
    if (l) m_pkt++;
    q.push_back('{m_beat, m_err, m_pkt, m_flag, m_fdata, m_fidx});
    tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; tvalid = 1'b1; tdata = 32'd1; tstrb = 4'hF;
    @(negedge clk);
    clear = 1'b0; tvalid = 1'b0;
    chk("clr_beat", beat, 0);
    chk("clr_err", err, 0);
    chk("clr_flag", err_flag, 0);
    chk("clr_fdata", fdata, 0);
    chk("clr_tready", tready, 0);
    model_reset();
    @(negedge clk);
    chk("clr_rerun_tready", tready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v[13];
    logic [31:0] p;
    v = '{
      '{1'b0, 32'd1,         4'h1, 1'b1, 1'b0},
      '{1'b0, 32'd3,         4'h1, 1'b1, 1'b0},
      '{1'b0, 32'd9,         4'h1, 1'b1, 1'b0},
      '{1'b0, 32'd27,        4'h1, 1'b1, 1'b0},
      '{1'b0, 32'd81,        4'h1, 1'b1, 1'b0},
      '{1'b1, 32'd1,         4'hF, 1'b0, 1'b0},
      '{1'b0, 32'd3,         4'hF, 1'b0, 1'b0},
      '{1'b0, 32'd10,        4'hF, 1'b0, 1'b1},
      '{1'b0, 32'd27,        4'hF, 1'b0, 1'b0},
      '{1'b0, 32'hFFFF_FF51, 4'h1, 1'b0, 1'b0},
      '{1'b0, 32'hDEAD_BEEF, 4'h0, 1'b0, 1'b0},
      '{1'b0, 32'h0000_03D9, 4'h2, 1'b1, 1'b1},
      '{1'b0, 32'h0000_088B, 4'hF, 1'b1, 1'b0}
    };
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_beat", beat, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_done", done, 0);
    chk("rst_fdata", fdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", tready, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("run_tready", tready, 1);

    for (int i = 0; i < 13; i++) begin
      if (v[i].clr) do_clear();
      @(negedge clk);
      push_beat(v[i].d, v[i].s, v[i].l, v[i].bad);
    end
    @(negedge clk);
    tvalid = 1'b0;
    @(negedge clk);
    chk("table_drained", q.size(), 0);
    chk("table_err", err, 2);
    chk("table_first_data", fdata, 10);
    chk("table_first_index", fidx, 2);
    chk("table_pkt", pkt, 2);

    do_clear();
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      push_beat(k == 21 ? 32'h6F7C_52B3 : m_e, 4'hF, 1'b0, 1'b0);
      m_e = m_e * 32'd3;
    end
    @(negedge clk);
    tvalid = 1'b0;
    @(negedge clk);
    chk("pow21_drained", q.size(), 0);
    chk("pow21_err", err, 0);
    chk("pow21_beat", beat, 22);

    @(negedge clk);
    push_beat(m_e, 4'hF, 1'b0, 1'b0);
    enable = 1'b0;
    m_e = m_e * 32'd3;
    @(negedge clk);
    chk("drop_tready", tready, 0);
    repeat (3) @(negedge clk);
    tvalid = 1'b0;
    chk("drop_drained", q.size(), 0);
    chk("drop_beat", beat, 23);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_tready", tready, 1);

    enable4 = 1'b1;
    @(negedge clk);
    chk("c4_tready_on", tready4, 1);
    p = 32'd1;
    for (int k = 0; k < 15; k++) begin
      tvalid4 = 1'b1;
      tdata4 = p;
      p = p * 32'd3;
      @(negedge clk);
    end
    tdata4 = p;
    @(negedge clk);
    chk("c4_done", done4, 1);
    chk("c4_tready_off", tready4, 0);
    chk("c4_beat", beat4, 15);
    chk("c4_err", err4, 0);
    chk("c4_pkt", pkt4, 0);
    clear4 = 1'b1;
    @(negedge clk);
    clear4 = 1'b0;
    tvalid4 = 1'b0;
    chk("c4_clr_beat", beat4, 0);
    chk("c4_clr_done", done4, 0);
    chk("c4_clr_tready", tready4, 0);
    chk("c4_clr_fidx", fidx4, 0);
    @(negedge clk);
    chk("c4_rerun_tready", tready4, 1);
    tvalid4 = 1'b1;
    tdata4 = 32'd1;
    @(negedge clk);
    tvalid4 = 1'b0;
    chk("c4_after_beat", beat4, 1);
    chk("c4_after_err", err4, 0);
    chk("c4_after_flag", err_flag4, 0);
    chk("c4_after_fdata", fdata4, 0);

`ifdef POW3_CHECKER_BACKPRESSURE_EN
    begin
      int low, accepted;
      low = 0;
      accepted = 0;
      sb_on = 1'b0;
      tvalid = 1'b1;
      repeat (8) begin
        if (!tready) low++;
        @(negedge clk);
        if (hs) accepted++;
      end
      tvalid = 1'b0;
      chk("bp_accepts", accepted, 6);
      chk("bp_low_cycles", low, 2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
